// File: rtl/airlock_pkg.sv
// Shared airlock definitions: controller state encoding and latched fault codes.
// The fill-and-pressurize stage imports this package as well.
package airlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_PUMP    = 3'd2,
        ST_HANDOFF = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_DOOR    = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector. The flop remembers "input was low last cycle" and clears on reset,
// so a level that is already high when reset releases never produces a pulse.
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic in,
    output logic pulse
);

    logic low_seen_reg;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            low_seen_reg <= 1'b0;
        end else begin
            low_seen_reg <= ~in;
        end
    end

    assign pulse = in & low_seen_reg;

endmodule

// File: rtl/drain_and_evacuate.sv
// Airlock drain-and-evacuate stage: door check, timed evacuation pump, one-cycle handoff pulse, latched faults.
// Optional macro FAULT_CODE_EN adds the FaultCode output (01 door, 10 timeout).
module drain_and_evacuate
    import airlock_pkg::*;
#(
    parameter int unsigned EVAC_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned CNT_W          = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             begin_DandE,
    input  logic             InnerClosed,
    input  logic             OuterClosed,
    input  logic             Evacuated,
    input  logic             FaultClear,
    output logic             PumpOn,
    output logic             Busy,
    output logic             begin_FandP,
    output logic             Fault,
`ifdef FAULT_CODE_EN
    output logic [1:0]       FaultCode,
`endif
    output logic [CNT_W-1:0] PumpCount
);

    localparam logic [CNT_W-1:0] EVAC_LAST    = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_reg, state_next;
    logic             req_pulse;
    logic             doors_closed;
    logic             evac_done;
    logic             timed_out;
    logic             pump_on_reg, busy_reg, begin_fandp_reg, fault_reg;
    logic [CNT_W-1:0] pump_count_reg;

    rise_detect u_rise_detect (
        .Clock (Clock),
        .Reset (Reset),
        .in    (begin_DandE),
        .pulse (req_pulse)
    );

    assign doors_closed = InnerClosed & OuterClosed;
    assign evac_done    = (pump_count_reg >= EVAC_LAST) & Evacuated;
    assign timed_out    = (pump_count_reg == TIMEOUT_LAST);

    // Pump-state priority: door fault, then success, then timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (req_pulse) state_next = ST_CHECK;
            ST_CHECK:   state_next = doors_closed ? ST_PUMP : ST_FAULT;
            ST_PUMP: begin
                if (!doors_closed)  state_next = ST_FAULT;
                else if (evac_done) state_next = ST_HANDOFF;
                else if (timed_out) state_next = ST_FAULT;
            end
            ST_HANDOFF: state_next = ST_IDLE;
            ST_FAULT:   if (FaultClear) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg       <= ST_IDLE;
            pump_on_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            begin_fandp_reg <= 1'b0;
            fault_reg       <= 1'b0;
            pump_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            pump_on_reg     <= (state_next == ST_PUMP);
            busy_reg        <= (state_next == ST_CHECK) || (state_next == ST_PUMP) ||
                               (state_next == ST_HANDOFF);
            begin_fandp_reg <= (state_next == ST_HANDOFF);
            fault_reg       <= (state_next == ST_FAULT);
            if ((state_next == ST_PUMP) && (state_reg != ST_PUMP)) begin
                pump_count_reg <= '0;
            end else if ((state_reg == ST_PUMP) && (pump_count_reg != CNT_MAX)) begin
                pump_count_reg <= pump_count_reg + 1'b1;
            end
        end
    end

    assign PumpOn      = pump_on_reg;
    assign Busy        = busy_reg;
    assign begin_FandP = begin_fandp_reg;
    assign Fault       = fault_reg;
    assign PumpCount   = pump_count_reg;

`ifdef FAULT_CODE_EN
    logic [1:0] fault_kind;
    logic [1:0] fault_code_reg;

    always_comb begin
        fault_kind = FC_NONE;
        if ((state_reg == ST_CHECK) && !doors_closed) begin
            fault_kind = FC_DOOR;
        end else if (state_reg == ST_PUMP) begin
            if (!doors_closed)                fault_kind = FC_DOOR;
            else if (!evac_done && timed_out) fault_kind = FC_TIMEOUT;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fault_code_reg <= FC_NONE;
        end else if ((state_reg == ST_FAULT) && FaultClear) begin
            fault_code_reg <= FC_NONE;
        end else if (fault_kind != FC_NONE) begin
            fault_code_reg <= fault_kind;
        end
    end

    assign FaultCode = fault_code_reg;
`endif

endmodule

// File: tb/tb_drain_and_evacuate.sv
// Directed bench for drain_and_evacuate with EVAC_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_drain_and_evacuate;

    localparam int unsigned EVAC    = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CW      = 6;

    logic          Clock;
    logic          Reset;
    logic          begin_DandE;
    logic          InnerClosed;
    logic          OuterClosed;
    logic          Evacuated;
    logic          FaultClear;
    logic          PumpOn;
    logic          Busy;
    logic          begin_FandP;
    logic          Fault;
`ifdef FAULT_CODE_EN
    logic [1:0]    FaultCode;
`endif
    logic [CW-1:0] PumpCount;

    int checks   = 0;
    int failures = 0;

    drain_and_evacuate #(
        .EVAC_CYCLES    (EVAC),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CW)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .begin_DandE (begin_DandE),
        .InnerClosed (InnerClosed),
        .OuterClosed (OuterClosed),
        .Evacuated   (Evacuated),
        .FaultClear  (FaultClear),
        .PumpOn      (PumpOn),
        .Busy        (Busy),
        .begin_FandP (begin_FandP),
        .Fault       (Fault),
`ifdef FAULT_CODE_EN
        .FaultCode   (FaultCode),
`endif
        .PumpCount   (PumpCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Raise the request so the next edge samples it, then drop it again.
    task automatic request();
        begin_DandE = 1'b1;
        tick();
        begin_DandE = 1'b0;
    endtask

    initial begin
        Reset       = 1'b0;
        begin_DandE = 1'b0;
        InnerClosed = 1'b1;
        OuterClosed = 1'b1;
        Evacuated   = 1'b1;
        FaultClear  = 1'b0;
        tick();
        tick();
        check("rst_pumpon", PumpOn, 0);
        check("rst_busy", Busy, 0);
        check("rst_fandp", begin_FandP, 0);
        check("rst_fault", Fault, 0);
        check("rst_count", PumpCount, 0);
        Reset = 1'b1;
        tick();
        check("idle_busy", Busy, 0);

        // 1: nominal handoff
        $display("test1 nominal");
        request();
        check("t1_check_busy", Busy, 1);
        check("t1_check_pump", PumpOn, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_pumpon", PumpOn, 1);
            check("t1_count", PumpCount, k);
            check("t1_nofandp", begin_FandP, 0);
        end
        tick();
        check("t1_fandp", begin_FandP, 1);
        check("t1_handoff_pump", PumpOn, 0);
        check("t1_handoff_busy", Busy, 1);
        tick();
        check("t1_fandp_end", begin_FandP, 0);
        check("t1_idle_busy", Busy, 0);

        // 2: door open at request
        $display("test2 door open at request");
        OuterClosed = 1'b0;
        request();
        check("t2_check_busy", Busy, 1);
        check("t2_check_pump", PumpOn, 0);
        tick();
        check("t2_fault", Fault, 1);
        check("t2_pump", PumpOn, 0);
        check("t2_busy", Busy, 0);
`ifdef FAULT_CODE_EN
        check("t2_code", FaultCode, 2'b01);
`endif
        request();
        tick();
        check("t2_fault_hold", Fault, 1);
        check("t2_ignore_req", Busy, 0);
        OuterClosed = 1'b1;
        FaultClear  = 1'b1;
        tick();
        FaultClear  = 1'b0;
        check("t2_cleared", Fault, 0);
`ifdef FAULT_CODE_EN
        check("t2_code_clr", FaultCode, 2'b00);
`endif

        // 3: pump timeout
        $display("test3 timeout");
        Evacuated = 1'b0;
        request();
        for (int k = 0; k < 16; k++) begin
            tick();
            check("t3_pumpon", PumpOn, 1);
            check("t3_nofault", Fault, 0);
        end
        tick();
        check("t3_fault", Fault, 1);
        check("t3_pump_off", PumpOn, 0);
        check("t3_nofandp", begin_FandP, 0);
`ifdef FAULT_CODE_EN
        check("t3_code", FaultCode, 2'b10);
`endif
        FaultClear = 1'b1;
        tick();
        FaultClear = 1'b0;
        check("t3_cleared", Fault, 0);
        check("t3_idle", Busy, 0);

        // 4: success in the timeout cycle wins
        $display("test4 boundary success at count 15");
        request();
        for (int k = 0; k < 16; k++) begin
            tick();
            check("t4_pumpon", PumpOn, 1);
        end
        check("t4_count15", PumpCount, 15);
        Evacuated = 1'b1;
        tick();
        check("t4_fandp", begin_FandP, 1);
        check("t4_nofault", Fault, 0);
        tick();
        check("t4_idle", Busy, 0);
        check("t4_nofault2", Fault, 0);

        // 5: inner door opens mid-pump
        $display("test5 mid-pump door open");
        request();
        tick();
        tick();
        tick();
        check("t5_count2", PumpCount, 2);
        InnerClosed = 1'b0;
        tick();
        check("t5_fault", Fault, 1);
        check("t5_nofandp", begin_FandP, 0);
        check("t5_pump_off", PumpOn, 0);
`ifdef FAULT_CODE_EN
        check("t5_code", FaultCode, 2'b01);
`endif
        tick();
        check("t5_nofandp2", begin_FandP, 0);
        InnerClosed = 1'b1;
        FaultClear  = 1'b1;
        tick();
        FaultClear  = 1'b0;
        check("t5_cleared", Fault, 0);

        // 6: async reset mid-pump, request held across release
        $display("test6 reset and hold");
        begin_DandE = 1'b1;
        tick();
        tick();
        check("t6_pumpon", PumpOn, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("t6_async_pump", PumpOn, 0);
        check("t6_async_busy", Busy, 0);
        check("t6_async_count", PumpCount, 0);
        tick();
        tick();
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_held_idle", Busy, 0);
            check("t6_held_pump", PumpOn, 0);
        end
        begin_DandE = 1'b0;
        tick();
        request();
        check("t6_fresh_edge", Busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
